// File: rtl/cpu_pkg.sv
// Shared CPU definitions: control-word layout and bubble encoding.
// The decoder, the ID/EX pipeline register and the forwarding unit all import
// this package, so the control-bit positions have a single definition.
package cpu_pkg;

  localparam int CTRL_W    = 8;
  localparam int REG_IDX_W = 5;

  // Bit positions inside the 8-bit control word.
  localparam int CTRL_REG_WRITE = 0;
  localparam int CTRL_MEM_READ  = 1;
  localparam int CTRL_MEM_WRITE = 2;
  localparam int CTRL_MEM_2_REG = 3;
  localparam int CTRL_ALU_SRC   = 4;
  localparam int CTRL_BRANCH    = 5;
  localparam int CTRL_ALU_OP    = 6;  // lsb of the 2-bit alu_op field
  localparam int CTRL_ALU_OP_W  = 2;

  // A bubble carries no side effects: no register write, no memory access.
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

endpackage : cpu_pkg

// File: rtl/hazard_detect.sv
// Load-use hazard detector (purely combinational).
// Flags when the instruction in EX is a load whose destination is read by the
// instruction currently in ID, so the consumer must wait one cycle.
// Ports:
//   valid_ex    - EX holds a real instruction
//   mem_read_ex - EX instruction is a load
//   rd_ex       - EX destination register
//   id_valid    - ID holds a real instruction
//   rs1_id      - ID source register 1
//   rs2_id      - ID source register 2
//   load_use    - stall request
module hazard_detect
  import cpu_pkg::*;
(
  input  logic                 valid_ex,
  input  logic                 mem_read_ex,
  input  logic [REG_IDX_W-1:0] rd_ex,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  output logic                 load_use
);

  logic rd_nonzero;
  logic rd_match;

  // x0 is hardwired zero, so a load targeting it never produces a dependency.
  assign rd_nonzero = (rd_ex != '0);
  assign rd_match   = (rd_ex == rs1_id) || (rd_ex == rs2_id);
  assign load_use   = valid_ex && mem_read_ex && rd_nonzero && id_valid && rd_match;

endmodule : hazard_detect

// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall and taken-branch flush control.
// Each cycle one of four things happens, highest priority first:
//   reset  : EX <- bubble, counters cleared
//   branch : EX <- bubble, IF/ID flushed, flush_cnt +1 (a coincident load-use
//            is irrelevant because the ID instruction is being discarded)
//   stall  : EX <- bubble, PC and IF/ID held, stall_cnt +1
//   normal : EX <- ID fields (or a bubble when ID is empty)
// The stall clears itself: the bubble it inserts has valid_ex=0, so the held
// consumer advances on the following cycle.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   id_valid, rs1_id, rs2_id, rd_id, rdata1_id, rdata2_id, imm_id, ctrl_id
//                       - ID stage instruction fields
//   branch_taken_ex     - EX resolved a taken branch this cycle
//   valid_ex .. ctrl_ex - registered EX-stage copies of the ID fields
//   pc_write            - PC update enable
//   if_id_write         - IF/ID register update enable
//   if_id_flush         - IF/ID register clear request
//   stall_cnt, flush_cnt- saturating event counters
module id_ex_pipe
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [REG_IDX_W-1:0] rs1_id,
  input  logic [REG_IDX_W-1:0] rs2_id,
  input  logic [REG_IDX_W-1:0] rd_id,
  input  logic [DATA_W-1:0]    rdata1_id,
  input  logic [DATA_W-1:0]    rdata2_id,
  input  logic [DATA_W-1:0]    imm_id,
  input  logic [CTRL_W-1:0]    ctrl_id,
  input  logic                 branch_taken_ex,
  output logic                 valid_ex,
  output logic [REG_IDX_W-1:0] rs1_ex,
  output logic [REG_IDX_W-1:0] rs2_ex,
  output logic [REG_IDX_W-1:0] rd_ex,
  output logic [DATA_W-1:0]    rdata1_ex,
  output logic [DATA_W-1:0]    rdata2_ex,
  output logic [DATA_W-1:0]    imm_ex,
  output logic [CTRL_W-1:0]    ctrl_ex,
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic load_use;
  logic do_flush;
  logic do_stall;
  logic load_bubble;

  hazard_detect u_hazard_detect (
    .valid_ex    (valid_ex),
    .mem_read_ex (ctrl_ex[CTRL_MEM_READ]),
    .rd_ex       (rd_ex),
    .id_valid    (id_valid),
    .rs1_id      (rs1_id),
    .rs2_id      (rs2_id),
    .load_use    (load_use)
  );

  // Priority resolution; reset masks both events so the control outputs read
  // as a normal cycle while rst is high.
  assign do_flush    = !rst && branch_taken_ex;
  assign do_stall    = !rst && !branch_taken_ex && load_use;
  assign load_bubble = rst || do_flush || do_stall || !id_valid;

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    if (do_flush) begin
      if_id_flush = 1'b1;
    end else if (do_stall) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
    end
  end

  // EX-stage register: either a bit-exact copy of ID or an all-zero bubble.
  always_ff @(posedge clk) begin
    if (load_bubble) begin
      valid_ex  <= 1'b0;
      rs1_ex    <= '0;
      rs2_ex    <= '0;
      rd_ex     <= '0;
      rdata1_ex <= '0;
      rdata2_ex <= '0;
      imm_ex    <= '0;
      ctrl_ex   <= BUBBLE_CTRL;
    end else begin
      valid_ex  <= 1'b1;
      rs1_ex    <= rs1_id;
      rs2_ex    <= rs2_id;
      rd_ex     <= rd_id;
      rdata1_ex <= rdata1_id;
      rdata2_ex <= rdata2_id;
      imm_ex    <= imm_id;
      ctrl_ex   <= ctrl_id;
    end
  end

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (do_stall && (stall_cnt != CNT_MAX)) begin
        stall_cnt <= stall_cnt + CNT_ONE;
      end
      if (do_flush && (flush_cnt != CNT_MAX)) begin
        flush_cnt <= flush_cnt + CNT_ONE;
      end
    end
  end

endmodule : id_ex_pipe

// File: tb/tb_id_ex_pipe.sv
// Directed bench for id_ex_pipe. A second instance with CNT_W=2 shares all
// inputs and is used for the counter saturation scenario.
module tb_id_ex_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [4:0]  rs1_id, rs2_id, rd_id;
  logic [31:0] rdata1_id, rdata2_id, imm_id;
  logic [7:0]  ctrl_id;
  logic        branch_taken_ex;

  logic        valid_ex;
  logic [4:0]  rs1_ex, rs2_ex, rd_ex;
  logic [31:0] rdata1_ex, rdata2_ex, imm_ex;
  logic [7:0]  ctrl_ex;
  logic        pc_write, if_id_write, if_id_flush;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_valid_ex;
  logic [4:0]  s_rs1_ex, s_rs2_ex, s_rd_ex;
  logic [31:0] s_rdata1_ex, s_rdata2_ex, s_imm_ex;
  logic [7:0]  s_ctrl_ex;
  logic        s_pc_write, s_if_id_write, s_if_id_flush;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int total = 0;
  int bad   = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  id_ex_pipe #(.DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id),
    .ctrl_id(ctrl_id), .branch_taken_ex(branch_taken_ex),
    .valid_ex(valid_ex), .rs1_ex(rs1_ex), .rs2_ex(rs2_ex), .rd_ex(rd_ex),
    .rdata1_ex(rdata1_ex), .rdata2_ex(rdata2_ex), .imm_ex(imm_ex),
    .ctrl_ex(ctrl_ex), .pc_write(pc_write), .if_id_write(if_id_write),
    .if_id_flush(if_id_flush), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_pipe #(.DATA_W(32), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .rdata1_id(rdata1_id), .rdata2_id(rdata2_id), .imm_id(imm_id),
    .ctrl_id(ctrl_id), .branch_taken_ex(branch_taken_ex),
    .valid_ex(s_valid_ex), .rs1_ex(s_rs1_ex), .rs2_ex(s_rs2_ex), .rd_ex(s_rd_ex),
    .rdata1_ex(s_rdata1_ex), .rdata2_ex(s_rdata2_ex), .imm_ex(s_imm_ex),
    .ctrl_ex(s_ctrl_ex), .pc_write(s_pc_write), .if_id_write(s_if_id_write),
    .if_id_flush(s_if_id_flush), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs change #1 after the edge, outputs sampled after.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] r1, input logic [31:0] r2,
                        input logic [31:0] imm, input logic [7:0] ctrl);
    id_valid  = v;
    rs1_id    = rs1;
    rs2_id    = rs2;
    rd_id     = rd;
    rdata1_id = r1;
    rdata2_id = r2;
    imm_id    = imm;
    ctrl_id   = ctrl;
  endtask

  task automatic set_idle();
    set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 8'd0);
    branch_taken_ex = 1'b0;
  endtask

  task automatic apply_reset();
    set_idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    // Junk ID instruction plus a branch while reset is high: reset must win.
    rst = 1'b1;
    set_id(1'b1, 5'd3, 5'd4, 5'd9, 32'h1234_5678, 32'h9abc_def0, 32'h55, 8'hFF);
    branch_taken_ex = 1'b1;
    #1;
    total++;
    if ({pc_write, if_id_write, if_id_flush} !== 3'b110) begin
      bad++;
      $display("FAIL reset_ctrl: got pc/ifid/flush=%b want 110", {pc_write, if_id_write, if_id_flush});
    end
    cyc();
    rst = 1'b0;
    set_idle();
    #1;
    total++;
    if ({valid_ex, rs1_ex, rs2_ex, rd_ex, rdata1_ex, rdata2_ex, imm_ex, ctrl_ex} !== '0) begin
      bad++;
      $display("FAIL reset_ex: got valid=%b rd=%0d ctrl=%h imm=%h want all zero", valid_ex, rd_ex, ctrl_ex, imm_ex);
    end
    total++;
    if ({stall_cnt, flush_cnt} !== 32'd0) begin
      bad++;
      $display("FAIL reset_cnt: got stall=%0d flush=%0d want 0 0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    apply_reset();
    // lw x5, 8(x1)
    set_id(1'b1, 5'd1, 5'd2, 5'd5, 32'h0000_0100, 32'h0, 32'h8, 8'h0B);
    cyc();
    total++;
    if ({valid_ex, rd_ex, ctrl_ex, imm_ex} !== {1'b1, 5'd5, 8'h0B, 32'h8}) begin
      bad++;
      $display("FAIL lu_load_in_ex: got valid=%b rd=%0d ctrl=%h imm=%h want 1 5 0b 8", valid_ex, rd_ex, ctrl_ex, imm_ex);
    end
    // add x7, x5, x6 sits in ID
    set_id(1'b1, 5'd5, 5'd6, 5'd7, 32'h1111_1111, 32'h2222_2222, 32'h0, 8'h01);
    #1;
    total++;
    if ({pc_write, if_id_write, if_id_flush} !== 3'b000) begin
      bad++;
      $display("FAIL lu_stall_ctrl: got pc/ifid/flush=%b want 000", {pc_write, if_id_write, if_id_flush});
    end
    cyc();
    total++;
    if ({valid_ex, rd_ex, ctrl_ex, stall_cnt} !== {1'b0, 5'd0, 8'h00, 16'd1}) begin
      bad++;
      $display("FAIL lu_bubble: got valid=%b rd=%0d ctrl=%h stall=%0d want 0 0 00 1", valid_ex, rd_ex, ctrl_ex, stall_cnt);
    end
    total++;
    if ({pc_write, if_id_write} !== 2'b11) begin
      bad++;
      $display("FAIL lu_release: got pc/ifid=%b want 11", {pc_write, if_id_write});
    end
    cyc();
    total++;
    if ({valid_ex, rs1_ex, rs2_ex, rd_ex, rdata1_ex, rdata2_ex, ctrl_ex, stall_cnt} !==
        {1'b1, 5'd5, 5'd6, 5'd7, 32'h1111_1111, 32'h2222_2222, 8'h01, 16'd1}) begin
      bad++;
      $display("FAIL lu_consumer: got valid=%b rs1=%0d rd=%0d r1=%h stall=%0d want 1 5 7 11111111 1",
               valid_ex, rs1_ex, rd_ex, rdata1_ex, stall_cnt);
    end
    set_idle();
  endtask

  task automatic test_rd_zero();
    apply_reset();
    // load targeting x0
    set_id(1'b1, 5'd1, 5'd0, 5'd0, 32'h40, 32'h0, 32'h4, 8'h0B);
    cyc();
    set_id(1'b1, 5'd0, 5'd0, 5'd3, 32'h0, 32'h0, 32'h0, 8'h01);
    #1;
    total++;
    if ({pc_write, if_id_write, if_id_flush} !== 3'b110) begin
      bad++;
      $display("FAIL rd0_ctrl: got pc/ifid/flush=%b want 110", {pc_write, if_id_write, if_id_flush});
    end
    cyc();
    total++;
    if ({valid_ex, rs2_ex, rd_ex, pc_write, stall_cnt} !== {1'b1, 5'd0, 5'd3, 1'b1, 16'd0}) begin
      bad++;
      $display("FAIL rd0_flow: got valid=%b rs2=%0d rd=%0d pc=%b stall=%0d want 1 0 3 1 0",
               valid_ex, rs2_ex, rd_ex, pc_write, stall_cnt);
    end
    set_idle();
  endtask

  task automatic test_branch_over_stall();
    apply_reset();
    set_id(1'b1, 5'd1, 5'd0, 5'd3, 32'h80, 32'h0, 32'h0, 8'h0B);
    cyc();
    // consumer of x3 and a taken branch in the same cycle
    set_id(1'b1, 5'd8, 5'd3, 5'd9, 32'h0, 32'h0, 32'h0, 8'h01);
    branch_taken_ex = 1'b1;
    #1;
    total++;
    if ({pc_write, if_id_write, if_id_flush} !== 3'b111) begin
      bad++;
      $display("FAIL br_ctrl: got pc/ifid/flush=%b want 111", {pc_write, if_id_write, if_id_flush});
    end
    cyc();
    branch_taken_ex = 1'b0;
    total++;
    if ({valid_ex, rd_ex, ctrl_ex, flush_cnt, stall_cnt} !== {1'b0, 5'd0, 8'h00, 16'd1, 16'd0}) begin
      bad++;
      $display("FAIL br_result: got valid=%b ctrl=%h flush=%0d stall=%0d want 0 00 1 0",
               valid_ex, ctrl_ex, flush_cnt, stall_cnt);
    end
    set_idle();
  endtask

  task automatic test_saturate();
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      set_id(1'b1, 5'd1, 5'd0, 5'd4, 32'h0, 32'h0, 32'h0, 8'h0B);
      branch_taken_ex = 1'b0;
      cyc();
      set_id(1'b1, 5'd4, 5'd2, 5'd6, 32'h0, 32'h0, 32'h0, 8'h01);
      cyc();
      total++;
      if (s_stall_cnt !== ((i + 1 > 3) ? 2'd3 : 2'(i + 1))) begin
        bad++;
        $display("FAIL sat_cnt%0d: got %0d want %0d", i, s_stall_cnt, (i + 1 > 3) ? 3 : i + 1);
      end
    end
    total++;
    if (stall_cnt !== 16'd5) begin
      bad++;
      $display("FAIL sat_wide_cnt: got %0d want 5", stall_cnt);
    end
    set_idle();
  endtask

  task automatic test_reset_mid_stall();
    // counters still hold stall counts from the previous scenario
    set_id(1'b1, 5'd1, 5'd0, 5'd5, 32'h0, 32'h0, 32'h10, 8'h0B);
    cyc();
    set_id(1'b1, 5'd5, 5'd2, 5'd7, 32'hAAAA_0001, 32'h0, 32'h0, 8'h01);
    rst = 1'b1;
    #1;
    total++;
    if ({pc_write, if_id_write, if_id_flush} !== 3'b110) begin
      bad++;
      $display("FAIL rst_stall_ctrl: got pc/ifid/flush=%b want 110", {pc_write, if_id_write, if_id_flush});
    end
    cyc();
    rst = 1'b0;
    #1;
    total++;
    if ({valid_ex, rs1_ex, rs2_ex, rd_ex, rdata1_ex, rdata2_ex, imm_ex, ctrl_ex,
         stall_cnt, flush_cnt, pc_write} !== {{(1+15+96+8+32){1'b0}}, 1'b1}) begin
      bad++;
      $display("FAIL rst_stall_after: got valid=%b rd=%0d stall=%0d flush=%0d pc=%b want 0 0 0 0 1",
               valid_ex, rd_ex, stall_cnt, flush_cnt, pc_write);
    end
    cyc();
    total++;
    if ({valid_ex, rs1_ex, rdata1_ex} !== {1'b1, 5'd5, 32'hAAAA_0001}) begin
      bad++;
      $display("FAIL rst_stall_resume: got valid=%b rs1=%0d r1=%h want 1 5 aaaa0001", valid_ex, rs1_ex, rdata1_ex);
    end
    set_idle();
  endtask

  task automatic test_back_to_back();
    logic [7:0] ops [4];
    ops[0] = 8'h81; ops[1] = 8'h11; ops[2] = 8'hC1; ops[3] = 8'h00;
    apply_reset();
    // ALU stream with tight register reuse; no loads, so never a stall
    for (int i = 0; i < 8; i++) begin
      set_id(1'b1, 5'(i + 1), 5'(i), 5'(i + 2), 32'hDEAD_BEEF, 32'(i * 32'h0101_0101),
             32'(i * 32'h1000_0001), ops[i % 4]);
      #1;
      total++;
      if (pc_write !== 1'b1) begin
        bad++;
        $display("FAIL alu_pc%0d: got %b want 1", i, pc_write);
      end
      cyc();
      total++;
      if ({valid_ex, rs1_ex, rs2_ex, rd_ex, rdata1_ex, rdata2_ex, imm_ex, ctrl_ex} !==
          {1'b1, 5'(i + 1), 5'(i), 5'(i + 2), 32'hDEAD_BEEF, 32'(i * 32'h0101_0101),
           32'(i * 32'h1000_0001), ops[i % 4]}) begin
        bad++;
        $display("FAIL alu_ex%0d: got rs1=%0d rd=%0d r1=%h r2=%h imm=%h ctrl=%h", i, rs1_ex, rd_ex,
                 rdata1_ex, rdata2_ex, imm_ex, ctrl_ex);
      end
    end
    // empty ID slot with stale field values must still produce a clean bubble
    set_id(1'b0, 5'd3, 5'd4, 5'd5, 32'hFFFF_FFFF, 32'h1, 32'h2, 8'h0B);
    cyc();
    total++;
    if ({valid_ex, rs1_ex, rs2_ex, rd_ex, rdata1_ex, rdata2_ex, imm_ex, ctrl_ex, stall_cnt} !== '0) begin
      bad++;
      $display("FAIL alu_bubble: got valid=%b rd=%0d r1=%h ctrl=%h stall=%0d want all zero",
               valid_ex, rd_ex, rdata1_ex, ctrl_ex, stall_cnt);
    end
    set_idle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1;
    set_idle();
    cyc();
    test_reset();
    test_load_use();
    test_rd_zero();
    test_branch_over_stall();
    test_saturate();
    test_reset_mid_stall();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_id_ex_pipe

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register-operand/immediate width.
REQ-002 SHALL have parameter CNT_W, default 16, width of each event counter.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  synchronous active-high reset.
REQ-005 SHALL have port id_valid  input  1  ID stage holds a real instruction.
REQ-006 SHALL have ports rs1_id/rs2_id/rd_id  input  5 each  ID source/destination register indices.
REQ-007 SHALL have ports rdata1_id/rdata2_id  input  DATA_W each  register-file read data.
REQ-008 SHALL have port imm_id  input  DATA_W  decoded immediate.
REQ-009 SHALL have port ctrl_id  input  8  control bits: [0] reg_write, [1] mem_read, [2] mem_write, [3] mem_2_reg, [4] alu_src, [5] branch, [7:6] alu_op.
REQ-010 SHALL have port branch_taken_ex  input  1  EX resolved a taken branch this cycle.
REQ-011 SHALL have ports valid_ex, rs1_ex, rs2_ex, rd_ex, rdata1_ex, rdata2_ex, imm_ex, ctrl_ex  output  widths as ID counterparts  registered EX-stage copies; rs1_ex/rs2_ex/rd_ex feed the forwarding unit.
REQ-012 SHALL have port pc_write  output  1  PC update enable.
REQ-013 SHALL have port if_id_write  output  1  IF/ID register update enable.
REQ-014 SHALL have port if_id_flush  output  1  IF/ID register clear request.
REQ-015 SHALL have ports stall_cnt/flush_cnt  output  CNT_W each  load-use stall / branch flush event counters.

Function
REQ-016 ID->EX latency SHALL be exactly one clk; all *_ex outputs and counters registered; pc_write, if_id_write, if_id_flush combinational from current *_ex state and ID/branch inputs.
REQ-017 load_use SHALL be valid_ex & ctrl_ex[1] & rd_ex!=0 & id_valid & (rd_ex==rs1_id | rd_ex==rs2_id).
REQ-018 Priority per cycle SHALL be rst > branch_taken_ex > load_use > normal.
REQ-019 Normal with id_valid=1: load all ID fields, valid_ex=1; pc_write=1, if_id_write=1, if_id_flush=0.
REQ-020 Normal with id_valid=0: load bubble; control outputs as REQ-019.
REQ-021 Bubble SHALL be valid_ex=0 and every other *_ex field zero.
REQ-022 load_use: load bubble; pc_write=0, if_id_write=0, if_id_flush=0; stall_cnt +1.
REQ-023 A load-use stall SHALL last exactly one cycle (bubble clears valid_ex); the held ID instruction enters EX next cycle.
REQ-024 branch_taken_ex: load bubble; pc_write=1, if_id_write=1, if_id_flush=1; flush_cnt +1; coincident load_use ignored, stall_cnt unchanged.
REQ-025 rd_ex==0 SHALL never cause a stall, even when rs1_id or rs2_id is 0.
REQ-026 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-027 Module SHALL never modify ID data; fields pass through bit-exact.

Reset
REQ-028 rst=1 at a rising edge SHALL load bubble and clear both counters, overriding branch/load_use; during rst pc_write=1, if_id_write=1, if_id_flush=0.
REQ-029 Reset asserted mid-stall SHALL drop the stall; first post-reset cycle behaves as normal.

Structure
REQ-030 Package cpu_pkg SHALL hold CTRL_W=8, ctrl bit indices (CTRL_REG_WRITE..CTRL_ALU_OP) and BUBBLE_CTRL=0, shared with decoder and forwarding unit.
REQ-031 Load-use compare SHALL be a combinational sub-module hazard_detect; id_ex_pipe holds registers, priority and counters.

Verification
REQ-032 Load x5 (ctrl 0x0B, rd=5) then id rs1=5 -> cycle after load enters EX: pc_write=0, if_id_write=0; next cycle valid_ex=0; next cycle consumer in EX with rs1_ex=5; stall_cnt=1.
REQ-033 Load rd=0 then id rs2=0 -> no stall, pc_write=1 continuously, stall_cnt=0.
REQ-034 branch_taken_ex=1 coincident with load_use -> if_id_flush=1, pc_write=1, valid_ex=0 next, flush_cnt=1, stall_cnt=0.
REQ-035 CNT_W=2, force 5 load-use stalls -> stall_cnt reads 3 after third and stays 3.
REQ-036 rst pulsed during stall cycle -> next cycle all *_ex zero, counters 0, pc_write=1.
REQ-037 Random ALU stream (no loads/branches), rdata1_id=0xDEADBEEF -> rdata1_ex=0xDEADBEEF one cycle later, no stalls.
